// File: rtl/i2c_pkg.sv
// Shared definitions for the i2c_arbiter: FSM state encoding and master status bit positions.
// GAP exists only when I2C_ARB_RETRY_EN is defined.
package i2c_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWaitBusy,
    StWaitDone,
    StComplete
`ifdef I2C_ARB_RETRY_EN
    , StGap
`endif
  } arb_state_e;

  localparam int unsigned StatBusy  = 31;
  localparam int unsigned StatAnack = 30;
  localparam int unsigned StatDnack = 29;
  localparam int unsigned StatRd    = 28;
  localparam int unsigned StatOvr   = 27;
  localparam int unsigned StatInit  = 26;

  // Completion snapshot: master status with the retry count in bits 25:24.
  function automatic logic [31:0] pack_result(input logic [31:0] status, input logic [1:0] retry);
    return {status[StatBusy], status[StatAnack], status[StatDnack], status[StatRd],
            status[StatOvr], status[StatInit], retry, status[23:0]};
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the first requester after index last_i (wrapping) wins.
module rr_pick #(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]         req_i,
  input  logic [$clog2(NREQ)-1:0] last_i,
  output logic [NREQ-1:0]         winner_o,
  output logic [$clog2(NREQ)-1:0] idx_o,
  output logic                    any_o
);
  localparam int unsigned IdxW = $clog2(NREQ);

  always_comb begin
    logic [IdxW-1:0] cand;
    cand     = '0;
    winner_o = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = IdxW'((32'(last_i) + k) % NREQ);
      if (!any_o && req_i[cand]) begin
        winner_o[cand] = 1'b1;
        idx_o          = cand;
        any_o          = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_arbiter.sv
// Round-robin arbiter sharing one i2c_master among NREQ requesters.
// Define I2C_ARB_RETRY_EN to re-issue a transaction after an address NACK.
module i2c_arbiter
  import i2c_pkg::*;
#(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned MAX_RETRY = 3,
  parameter int unsigned RETRY_GAP = 255
) (
  input  logic               sys_clock,
  input  logic               reset,
  input  logic [NREQ-1:0]    req,
  input  logic [32*NREQ-1:0] req_ctrl,
  output logic [NREQ-1:0]    grant,
  output logic [NREQ-1:0]    done,
  output logic [31:0]        result,
  output logic [31:0]        m_ctrl_data,
  output logic               m_wr_ctrl,
  input  logic [31:0]        m_status
);
  localparam int unsigned IdxW = $clog2(NREQ);

  arb_state_e      state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [31:0]     result_q, result_d;
  logic [31:0]     m_ctrl_data_q, m_ctrl_data_d;
  logic [31:0]     ctrl_q, ctrl_d;
  logic            m_wr_ctrl_q, m_wr_ctrl_d;
  logic [IdxW-1:0] owner_q, owner_d;
  logic [IdxW-1:0] last_q, last_d;
  logic [1:0]      retry_q, retry_d;
  logic [NREQ-1:0] pick_oh;
  logic [IdxW-1:0] pick_idx;
  logic            pick_any;
  logic            finish;
  logic            again;

`ifdef I2C_ARB_RETRY_EN
  localparam int unsigned GapW = $clog2(RETRY_GAP + 1);
  logic [GapW-1:0] gap_q, gap_d;
  logic            again_q, again_d;
  assign again = m_status[StatAnack] && (32'(retry_q) < MAX_RETRY);
`else
  logic unused_cfg;
  assign unused_cfg = ^{MAX_RETRY, RETRY_GAP};
  assign again      = 1'b0;
`endif

  rr_pick #(
    .NREQ(NREQ)
  ) u_rr_pick (
    .req_i   (req),
    .last_i  (last_q),
    .winner_o(pick_oh),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    result_d      = result_q;
    m_ctrl_data_d = m_ctrl_data_q;
    m_wr_ctrl_d   = 1'b0;
    ctrl_d        = ctrl_q;
    owner_d       = owner_q;
    last_d        = last_q;
    retry_d       = retry_q;
    finish        = 1'b0;
`ifdef I2C_ARB_RETRY_EN
    gap_d         = gap_q;
    again_d       = again_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (!m_status[StatBusy] && pick_any) begin
          grant_d = pick_oh;
          owner_d = pick_idx;
          ctrl_d  = req_ctrl[32*pick_idx +: 32];
          retry_d = '0;
          state_d = StIssue;
        end
      end
      StIssue: begin
        m_wr_ctrl_d   = 1'b1;
        m_ctrl_data_d = ctrl_q;
        state_d       = StWaitBusy;
      end
      StWaitBusy: if (m_status[StatBusy]) state_d = StWaitDone;
      StWaitDone: begin
        // Snapshot the status on the idle edge; a retried attempt leaves result untouched.
        if (!m_status[StatBusy]) begin
          if (!again) result_d = pack_result(m_status, retry_q);
`ifdef I2C_ARB_RETRY_EN
          again_d = again;
`endif
          state_d = StComplete;
        end
      end
`ifdef I2C_ARB_RETRY_EN
      StComplete: begin
        if (again_q) begin
          retry_d = retry_q + 1'b1;
          gap_d   = '0;
          state_d = StGap;
        end else begin
          finish = 1'b1;
        end
      end
      StGap: begin
        if (gap_q == GapW'(RETRY_GAP - 1)) state_d = StIssue;
        else gap_d = gap_q + 1'b1;
      end
`else
      StComplete: finish = 1'b1;
`endif
      default: state_d = StIdle;
    endcase
    if (finish) begin
      grant_d = '0;
      last_d  = owner_q;
      state_d = StIdle;
    end
  end

  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      grant_q       <= '0;
      result_q      <= '0;
      m_ctrl_data_q <= '0;
      m_wr_ctrl_q   <= 1'b0;
      ctrl_q        <= '0;
      owner_q       <= '0;
      last_q        <= IdxW'(NREQ - 1);
      retry_q       <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      result_q      <= result_d;
      m_ctrl_data_q <= m_ctrl_data_d;
      m_wr_ctrl_q   <= m_wr_ctrl_d;
      ctrl_q        <= ctrl_d;
      owner_q       <= owner_d;
      last_q        <= last_d;
      retry_q       <= retry_d;
    end
  end

`ifdef I2C_ARB_RETRY_EN
  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) begin
      gap_q   <= '0;
      again_q <= 1'b0;
    end else begin
      gap_q   <= gap_d;
      again_q <= again_d;
    end
  end
`endif

  // done is high during COMPLETE so the following IDLE cycle sees a fresh request level.
  assign done        = finish ? grant_q : '0;
  assign grant       = grant_q;
  assign result      = result_q;
  assign m_ctrl_data = m_ctrl_data_q;
  assign m_wr_ctrl   = m_wr_ctrl_q;

endmodule

// File: tb/tb_i2c_arbiter.sv
// Self-checking bench for i2c_arbiter: behavioural i2c_master model, transaction-level
// arbitration model with a per-cycle compare process, and directed scenarios.
module tb_i2c_arbiter;
  localparam int NREQ      = 4;
  localparam int MAX_RETRY = 3;
  localparam int RETRY_GAP = 20;

  logic               sys_clock;
  logic               reset;
  logic [NREQ-1:0]    req;
  logic [32*NREQ-1:0] req_ctrl;
  logic [NREQ-1:0]    grant;
  logic [NREQ-1:0]    done;
  logic [31:0]        result;
  logic [31:0]        m_ctrl_data;
  logic               m_wr_ctrl;
  logic [31:0]        m_status;

  int n_cmp = 0;
  int n_bad = 0;

  i2c_arbiter #(
    .NREQ     (NREQ),
    .MAX_RETRY(MAX_RETRY),
    .RETRY_GAP(RETRY_GAP)
  ) dut (
    .sys_clock  (sys_clock),
    .reset      (reset),
    .req        (req),
    .req_ctrl   (req_ctrl),
    .grant      (grant),
    .done       (done),
    .result     (result),
    .m_ctrl_data(m_ctrl_data),
    .m_wr_ctrl  (m_wr_ctrl),
    .m_status   (m_status)
  );

  initial begin
    sys_clock = 1'b0;
    forever #5 sys_clock = ~sys_clock;
  end

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endfunction

  // ---------------- i2c_master model ----------------
  int          cyc = 0;
  int          mst_init = 20;
  int          mst_cnt = 0;
  int          txn_len = 10;
  logic [31:0] mst_stat = '0;
  logic [31:0] mst_resp = '0;
  int          strobe_q[$];
  int          done_q[$];

  always @(posedge sys_clock) cyc <= cyc + 1;

  always @(posedge sys_clock or posedge reset) begin
    if (reset) begin
      mst_init <= 20;
      mst_cnt  <= 0;
      mst_stat <= '0;
    end else begin
      if (m_wr_ctrl) strobe_q.push_back(cyc);
      if (mst_init != 0) mst_init <= mst_init - 1;
      else if (mst_cnt != 0) begin
        mst_cnt <= mst_cnt - 1;
        if (mst_cnt == 1) mst_stat <= mst_resp;
      end else if (m_wr_ctrl) mst_cnt <= txn_len;
    end
  end

  assign m_status = (mst_init != 0 || mst_cnt != 0) ? (mst_stat | 32'h8000_0000) : mst_stat;

  // ---------------- arbitration model ----------------
  function automatic int rr_model(input logic [NREQ-1:0] r, input int last);
    for (int k = 1; k <= NREQ; k++) if (r[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  initial begin
    int              m_last;
    int              exp_owner;
    int              txn_strobes;
    int              exp_n;
    int              w;
    logic [31:0]     exp_word;
    logic [31:0]     exp_res;
    logic [NREQ-1:0] prev_req;
    logic [32*NREQ-1:0] prev_ctrl;
    logic            prev_busy;
    logic            prev_done;
    m_last = NREQ - 1; exp_owner = -1; txn_strobes = 0; exp_word = '0;
    prev_req = '0; prev_ctrl = '0; prev_busy = 1'b1; prev_done = 1'b0;
    forever begin
      @(negedge sys_clock or posedge reset);
      if (reset) begin
        m_last = NREQ - 1; exp_owner = -1; txn_strobes = 0;
        prev_req = '0; prev_busy = 1'b1; prev_done = 1'b0;
      end else begin
        if (exp_owner < 0 && grant != '0) begin
          w = rr_model(prev_req, m_last);
          check("grant_pick", 32'(grant), (w < 0) ? 32'h0 : 32'(1 << w));
          check("grant_master_idle", 32'(prev_busy), 0);
          check("grant_after_done_gap", 32'(prev_done), 0);
          exp_owner   = (w < 0) ? onehot_idx(grant) : w;
          exp_word    = prev_ctrl[32*exp_owner +: 32];
          txn_strobes = 0;
        end else if (exp_owner >= 0) begin
          check("grant_stable", 32'(grant), 32'(1 << exp_owner));
        end
        if (m_wr_ctrl) begin
          check("wr_has_owner", 32'(exp_owner >= 0), 1);
          check("wr_word", m_ctrl_data, exp_word);
          txn_strobes++;
        end
        if (done != '0) begin
          done_q.push_back(cyc);
          check("done_owner", 32'(done), (exp_owner < 0) ? 32'h0 : 32'(1 << exp_owner));
          exp_res = mst_resp;
`ifdef I2C_ARB_RETRY_EN
          exp_n = mst_resp[30] ? MAX_RETRY + 1 : 1;
          exp_res[25:24] = 2'(txn_strobes - 1);
`else
          exp_n = 1;
`endif
          check("done_result", result, exp_res);
          check("strobes_per_txn", txn_strobes, exp_n);
          if (exp_owner >= 0) m_last = exp_owner;
          exp_owner = -1;
        end
        prev_req  = req;
        prev_ctrl = req_ctrl;
        prev_busy = m_status[31];
        prev_done = (done != '0);
      end
    end
  end

  // ---------------- directed scenarios ----------------
  task automatic do_reset();
    @(posedge sys_clock);
    #1 reset = 1'b1;
    req = '0;
    @(posedge sys_clock);
    #1 reset = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag, output int owner);
    owner = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge sys_clock);
      if (done != '0) begin
        owner = onehot_idx(done);
        return;
      end
    end
    n_cmp++;
    n_bad++;
    $display("FAIL %s: no done within %0d cycles, got none, required one", tag, budget);
  endtask

  task automatic wait_wr(input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      @(negedge sys_clock);
      if (m_wr_ctrl) return;
    end
    n_cmp++;
    n_bad++;
    $display("FAIL %s: no m_wr_ctrl within %0d cycles", tag, budget);
  endtask

  initial begin
    int   own;
    int   sbase;
    int   dbase;
    int   busy_cyc;
    int   lat;
    logic saw_grant;
    logic gap_ok;
    reset = 1'b1;
    req = '0;
    req_ctrl = '0;
    repeat (3) @(posedge sys_clock);
    @(negedge sys_clock);
    check("rst_grant", 32'(grant), 0);
    check("rst_done", 32'(done), 0);
    check("rst_result", result, 0);
    check("rst_m_ctrl_data", m_ctrl_data, 0);
    check("rst_m_wr_ctrl", 32'(m_wr_ctrl), 0);
    @(posedge sys_clock);
    #1 reset = 1'b0;

    // Master initialising: no grant until busy drops, then strobe two cycles later.
    req_ctrl[31:0] = 32'h1234_5678;
    mst_resp = 32'h0000_0011;
    req = 4'b0001;
    busy_cyc = 0;
    saw_grant = 1'b0;
    @(negedge sys_clock);
    while (m_status[31] && busy_cyc < 40) begin
      if (grant != '0) saw_grant = 1'b1;
      busy_cyc++;
      @(negedge sys_clock);
    end
    check("init_no_grant", 32'(saw_grant), 0);
    lat = 0;
    while (!m_wr_ctrl && lat < 10) begin
      @(negedge sys_clock);
      lat++;
    end
    check("wr_latency", lat, 2);
    check("first_word", m_ctrl_data, 32'h1234_5678);
    wait_done(200, "t1_done", own);
    check("t1_owner", own, 0);
    check("t1_result", result, 32'h0000_0011);
    @(posedge sys_clock);
    #1 req = '0;

    // All requesting, 50-cycle transactions: strict rotation from requester 0.
    do_reset();
    txn_len = 50;
    mst_resp = 32'h0000_0055;
    for (int i = 0; i < NREQ; i++) req_ctrl[32*i +: 32] = 32'hA0 + i;
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_done(400, "rr_done", own);
      check("rr_order", own, i % NREQ);
    end
    @(posedge sys_clock);
    #1 req = '0;

    // Read transaction status snapshot; exactly one done.
    do_reset();
    txn_len = 10;
    req_ctrl[95:64] = 32'h806F_0000;
    mst_resp = 32'h1000_00A5;
    sbase = strobe_q.size();
    dbase = done_q.size();
    req = 4'b0100;
    wait_done(200, "read_done", own);
    check("read_owner", own, 2);
    check("read_result", result, 32'h1000_00A5);
    @(posedge sys_clock);
    #1 req = '0;
    repeat (60) @(negedge sys_clock);
    check("read_done_count", done_q.size() - dbase, 1);
    check("read_strobes", strobe_q.size() - sbase, 1);

    // Request dropped while waiting for busy: still completes once.
    do_reset();
    req_ctrl[63:32] = 32'h0042_1234;
    mst_resp = 32'h2000_0000;
    sbase = strobe_q.size();
    req = 4'b0010;
    wait_wr(100, "drop_wr");
    @(posedge sys_clock);
    #1 req = '0;
    wait_done(200, "drop_done", own);
    check("drop_owner", own, 1);
    check("drop_result", result, 32'h2000_0000);
    repeat (30) @(negedge sys_clock);
    check("drop_strobes", strobe_q.size() - sbase, 1);

    // Reset during WAIT_DONE aborts; service resumes afterwards.
    do_reset();
    req_ctrl[31:0] = 32'h0000_0077;
    req_ctrl[127:96] = 32'h0000_0099;
    mst_resp = 32'h0000_0005;
    dbase = done_q.size();
    req = 4'b1001;
    for (int i = 0; i < 100 && !(grant != '0 && m_status[31]); i++) @(negedge sys_clock);
    check("abort_in_txn", 32'(grant != '0 && m_status[31]), 1);
    @(negedge sys_clock);
    #2 reset = 1'b1;
    #1;
    check("abort_grant", 32'(grant), 0);
    check("abort_done", 32'(done), 0);
    check("abort_wr", 32'(m_wr_ctrl), 0);
    check("abort_no_done_pulse", done_q.size() - dbase, 0);
    @(posedge sys_clock);
    #1 reset = 1'b0;
    wait_done(200, "resume_done0", own);
    check("resume_owner0", own, 0);
    wait_done(200, "resume_done3", own);
    check("resume_owner3", own, 3);
    @(posedge sys_clock);
    #1 req = '0;

    // Master always NACKs the address.
    do_reset();
    req_ctrl[31:0] = 32'h0000_005A;
    mst_resp = 32'h4000_0000;
    sbase = strobe_q.size();
    req = 4'b0001;
    wait_done(2000, "nack_done", own);
    check("nack_owner", own, 0);
`ifdef I2C_ARB_RETRY_EN
    check("nack_result", result, 32'h4300_0000);
    check("nack_strobes", strobe_q.size() - sbase, MAX_RETRY + 1);
    gap_ok = 1'b1;
    for (int k = sbase + 1; k < strobe_q.size(); k++)
      if (strobe_q[k] - strobe_q[k-1] < RETRY_GAP) gap_ok = 1'b0;
    check("nack_spacing", 32'(gap_ok), 1);
`else
    gap_ok = 1'b1;
    check("nack_result", result, 32'h4000_0000);
    check("nack_strobes", strobe_q.size() - sbase, 1);
`endif
    @(posedge sys_clock);
    #1 req = '0;
    repeat (5) @(negedge sys_clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
